// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray counter: direction encoding and Gray/popcount functions.
// Functions operate on MAX_WIDTH bits; callers zero-extend and truncate to their own width.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 16;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1'b1);
  endfunction

  function automatic logic [4:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_counter_binary_to_gray.sv
// Combinational binary-to-reflected-Gray conversion, parameterised to WIDTH.
module binary_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] binary_in,
  output logic [WIDTH-1:0] gray_out
);

  assign gray_out = binary_in ^ (binary_in >> 1'b1);

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with registered binary and Gray views, wrap pulse and optional
// Gray-adjacency checker (build with GRAY_CHECK_EN to enable gray_err).
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap,
  output logic             gray_err
);

  localparam logic [WIDTH-1:0] RESET_BIN  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin2gray(MAX_WIDTH'(RESET_BIN)));
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             step_s;

  assign step_s = en & ~load;

  // Next-state: load beats enable; wrap only flags a counting rollover.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      case (dir_e'(dir))
        DIR_UP: begin
          bin_d  = bin_q + ONE;
          wrap_d = (bin_q == ALL_ONES);
        end
        DIR_DOWN: begin
          bin_d  = bin_q - ONE;
          wrap_d = (bin_q == '0);
        end
        default: begin
          bin_d  = bin_q;
          wrap_d = 1'b0;
        end
      endcase
    end else begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
    end
  end

  binary_to_gray #(.WIDTH(WIDTH)) u_bin2gray (
    .binary_in (bin_d),
    .gray_out  (gray_d)
  );

  // Count, Gray view and wrap pulse all register on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= RESET_BIN;
      gray_q <= RESET_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

`ifdef GRAY_CHECK_EN
  logic err_q, err_d;

  // Sticky flag: a counting step must flip exactly one Gray bit versus the previous output.
  always_comb begin
    err_d = err_q;
    if (step_s && (popcount(MAX_WIDTH'(gray_d ^ gray_q)) != 5'd1)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign gray_err = err_q;
`else
  logic unused_step_s;
  assign unused_step_s = step_s;
  assign gray_err      = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (WIDTH=4, RESET_VAL=0): vector table, corner sequences,
// and randomized stimulus against a reflected-Gray reference model.
module tb_gray_counter;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         dir = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] bin_out, gray_out;
  logic         wrap, gray_err;

  int n_pass  = 0;
  int n_total = 0;

  gray_counter #(.WIDTH(W), .RESET_VAL(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .bin_out  (bin_out),
    .gray_out (gray_out),
    .wrap     (wrap),
    .gray_err (gray_err)
  );

  always #5 clk = ~clk;

  // Reference Gray table built by reflect-and-prefix construction.
  logic [W-1:0] gray_tbl [N];

  typedef struct {
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         dir;
    logic [W-1:0] exp_bin;
    logic [W-1:0] exp_gray;
    logic         exp_wrap;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic l, input logic [W-1:0] lv, input logic e, input logic d);
    load = l; load_val = lv; en = e; dir = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #7;
    rst = 1'b0;
    @(negedge clk);
  endtask

  int model_cnt;
  logic model_wrap;

  initial begin
    // Reflected Gray construction
    gray_tbl[0] = '0;
    for (int k = 0; k < W; k++) begin
      for (int i = 0; i < (1 << k); i++) begin
        gray_tbl[(1 << k) + i] = gray_tbl[(1 << k) - 1 - i] | W'(1 << k);
      end
    end

    vecs[0]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd15, 4'b1000, 1'b1};
    vecs[1]  = '{1'b1, 4'd10, 1'b1, 1'b1, 4'd10, 4'b1111, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd11, 4'b1110, 1'b0};
    vecs[3]  = '{1'b1, 4'd15, 1'b0, 1'b0, 4'd15, 4'b1000, 1'b0};
    vecs[4]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  4'b0000, 1'b1};
    vecs[5]  = '{1'b1, 4'd0,  1'b1, 1'b0, 4'd0,  4'b0000, 1'b0};
    vecs[6]  = '{1'b0, 4'd3,  1'b0, 1'b1, 4'd0,  4'b0000, 1'b0};
    vecs[7]  = '{1'b1, 4'd6,  1'b0, 1'b0, 4'd6,  4'b0101, 1'b0};
    vecs[8]  = '{1'b0, 4'd0,  1'b0, 1'b1, 4'd6,  4'b0101, 1'b0};
    vecs[9]  = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd6,  4'b0101, 1'b0};
    vecs[10] = '{1'b0, 4'd9,  1'b0, 1'b1, 4'd6,  4'b0101, 1'b0};
    vecs[11] = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd6,  4'b0101, 1'b0};
    vecs[12] = '{1'b0, 4'd0,  1'b0, 1'b1, 4'd6,  4'b0101, 1'b0};
    vecs[13] = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd5,  4'b0111, 1'b0};

    // Reset state
    #3;
    check("reset_bin", bin_out, 0);
    check("reset_gray", gray_out, 0);
    check("reset_wrap", wrap, 0);
    check("reset_err", gray_err, 0);
    do_reset();

    // Full up sweep: 0..15 then back to 0 with one wrap
    drive(1'b0, '0, 1'b1, 1'b1);
    for (int i = 1; i <= N; i++) begin
      tick();
      check("sweep_bin", bin_out, i % N);
      check("sweep_gray", gray_out, gray_tbl[i % N]);
      check("sweep_wrap", wrap, (i == N) ? 1 : 0);
    end

    // Vector table (starts from bin_out = 0)
    for (int v = 0; v < 14; v++) begin
      drive(vecs[v].load, vecs[v].load_val, vecs[v].en, vecs[v].dir);
      tick();
      check($sformatf("vec%0d_bin", v), bin_out, vecs[v].exp_bin);
      check($sformatf("vec%0d_gray", v), gray_out, vecs[v].exp_gray);
      check($sformatf("vec%0d_wrap", v), wrap, vecs[v].exp_wrap);
    end

    // Async reset mid-count at 9, between edges
    drive(1'b1, 4'd8, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    check("pre_rst_bin", bin_out, 9);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_bin", bin_out, 0);
    check("async_rst_gray", gray_out, 0);
    check("async_rst_wrap", wrap, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("resume_bin", bin_out, 1);
    check("resume_gray", gray_out, gray_tbl[1]);

    // Randomized run against the arithmetic model
    model_cnt = 1;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 9) == 0), W'($urandom), ($urandom_range(0, 3) != 0),
            1'($urandom));
      if (load) begin
        model_cnt  = int'(load_val);
        model_wrap = 1'b0;
      end else if (en) begin
        model_wrap = dir ? (model_cnt == N - 1) : (model_cnt == 0);
        model_cnt  = (model_cnt + (dir ? 1 : N - 1)) % N;
      end else begin
        model_wrap = 1'b0;
      end
      tick();
      check("rand_bin", bin_out, model_cnt);
      check("rand_gray", gray_out, gray_tbl[model_cnt]);
      check("rand_wrap", wrap, model_wrap);
      check("rand_err", gray_err, 0);
    end

`ifdef GRAY_CHECK_EN
    // Force a +2 jump on the next-count path; the checker must latch the error
    do_reset();
    drive(1'b0, '0, 1'b1, 1'b1);
    force dut.bin_d = 4'd2;
    tick();
    release dut.bin_d;
    check("err_set", gray_err, 1);
    tick();
    tick();
    check("err_sticky", gray_err, 1);
    do_reset();
    check("err_cleared", gray_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
